jb_dfe_demixer: RTL and testbench
=================================

JB_DFE_DEMIXER -- requirements
Module: jb_dfe_demixer

Interface
- REQ-001 Parameter N_CARRIERS, default 2: carriers extracted per antenna.
- REQ-002 Parameter N_ANTENNAS, default 4: antenna streams in.
- REQ-003 Parameter NCO_ACC_WIDTH, default 32: phase accumulator and coefficient width, unsigned modulo 2^W.
- REQ-004 Parameter NCO_QUAD_LKUP_TBL_ENTRIES, default 1024: quarter-wave table resolution, power of 2.
- REQ-005 Parameter PRECISION, default 16: I/Q sample width, two's complement.
- REQ-006 clk  input  1  sole clock, all logic rising-edge.
- REQ-007 resetn  input  1  asynchronous active-low reset.
- REQ-008 nco_coef  input  N_CARRIERS x NCO_ACC_WIDTH  per-carrier phase increment per sample.
- REQ-009 nco_phase_rst  input  1  single-cycle pulse, zeroes all phase accumulators.
- REQ-010 tvalid_in  input  N_ANTENNAS  per-antenna sample valid.
- REQ-011 tdata_in  input  N_ANTENNAS x 2*PRECISION  composite sample, {Q,I}, I in LSBs.
- REQ-012 tvalid_out  output  N_CARRIERS x N_ANTENNAS  per carrier/antenna valid.
- REQ-013 tdata_out  output  N_CARRIERS x N_ANTENNAS x 2*PRECISION  downconverted sample, {Q,I}.
- REQ-014 sat_flag  output  N_CARRIERS  sticky, set on any saturation in that carrier's outputs.

Function
- REQ-015 Sample event = any tvalid_in bit high; one phase accumulator per carrier, shared across antennas.
- REQ-016 Sample event uses current accumulator value phi; accumulator then updates to phi+nco_coef[c] mod 2^W.
- REQ-017 Accumulator holds when no sample event; nco_coef change takes effect on the next sample event.
- REQ-018 nco_phase_rst: sample in same cycle uses phi=0, accumulator loads nco_coef[c] if sample event, else 0; reset wins over increment.
- REQ-019 Phase index: q = phi[W-1:W-2], idx = next log2(ENTRIES) bits; lower bits truncated.
- REQ-020 Table T[k] = round((2^(PRECISION-1)-1)*sin(pi/2*k/ENTRIES)), k=0..ENTRIES (ENTRIES+1 entries), built at elaboration.
- REQ-021 q0: sin=T[idx], cos=T[E-idx]; q1: sin=T[E-idx], cos=-T[idx]; q2: sin=-T[idx], cos=-T[E-idx]; q3: sin=-T[E-idx], cos=T[idx].
- REQ-022 Downconversion by exp(-j*phi): I' = I*cos + Q*sin; Q' = Q*cos - I*sin; full-precision products and sums, no intermediate truncation.
- REQ-023 Rounding: add 2^(PRECISION-2), arithmetic shift right by PRECISION-1 (round half up).
- REQ-024 Saturation: clamp to [-2^(PRECISION-1), 2^(PRECISION-1)-1]; any clamp of I' or Q' on a valid output sets sat_flag[c].
- REQ-025 Latency fixed at 5 cycles: tvalid_in[a] high at cycle n gives tvalid_out[c][a] high at cycle n+5 for every c; no backpressure.
- REQ-026 Stages: 1 input/phase register, 2 table read, 3 products, 4 sums, 5 round/saturate output register.
- REQ-027 Back-to-back samples every cycle sustained; valid pipeline is independent per antenna.
- REQ-028 tdata_out holds last value when tvalid_out low; downstream qualifies with tvalid_out.
- REQ-029 sat_flag clears only on resetn.

Reset
- REQ-030 resetn low: accumulators, pipeline valids, tdata_out, sat_flag all 0, asynchronously.
- REQ-031 Reset mid-stream: in-flight samples discarded, no tvalid_out for 5 cycles after release; first post-reset sample uses phi=0.
- REQ-032 Table contents unaffected by reset.

Verification
- REQ-033 Reset release, coef=0, antenna0 I=16384 Q=0 -> 5 cycles later all carriers ant0 I'=16384, Q'=0, sat_flag=0.
- REQ-034 coef[0]=2^30 (quarter turn), two samples I=16384 Q=0 -> carrier0 second output I'=0, Q'=-16383.
- REQ-035 coef=2^29 (45 deg), sample 0 then sample I=Q=32767 -> second output I'=32767 saturated, Q'=0, sat_flag[c]=1 and stays 1.
- REQ-036 nco_phase_rst coincident with sample after 3 events of coef=2^30 -> that sample output equals input (phase 0); next sample uses 90 deg.
- REQ-037 Continuous valid 100 cycles with random gaps on antenna subsets -> each tvalid_out exactly 5 cycles after its input, accumulator advances only on events; matches reference model bit-exact.
- REQ-038 resetn asserted with 3 samples in flight -> no tvalid_out emerges; outputs 0 immediately.

Source files
------------

// File: rtl/jb_dfe_demixer.sv
// Multi-carrier, multi-antenna digital downconverter.
// One NCO per carrier is shared by all antennas and advances once per sample
// event. Each antenna stream is mixed by exp(-j*phi), then rounded and
// saturated. The pipeline has a fixed 5-cycle latency:
// phase, table read, products, sums, round/saturate.
module jb_dfe_demixer #(
  parameter int N_CARRIERS                = 2,
  parameter int N_ANTENNAS                = 4,
  parameter int NCO_ACC_WIDTH             = 32,
  parameter int NCO_QUAD_LKUP_TBL_ENTRIES = 1024,
  parameter int PRECISION                 = 16
) (
  input  logic                                                    clk,
  input  logic                                                    resetn,
  input  logic [N_CARRIERS-1:0][NCO_ACC_WIDTH-1:0]                nco_coef,
  input  logic                                                    nco_phase_rst,
  input  logic [N_ANTENNAS-1:0]                                   tvalid_in,
  input  logic [N_ANTENNAS-1:0][2*PRECISION-1:0]                  tdata_in,
  output logic [N_CARRIERS-1:0][N_ANTENNAS-1:0]                   tvalid_out,
  output logic [N_CARRIERS-1:0][N_ANTENNAS-1:0][2*PRECISION-1:0]  tdata_out,
  output logic [N_CARRIERS-1:0]                                   sat_flag
);

  localparam int W      = NCO_ACC_WIDTH;
  localparam int E      = NCO_QUAD_LKUP_TBL_ENTRIES;
  localparam int IDX_W  = $clog2(E);
  localparam int P      = PRECISION;
  localparam int PROD_W = 2 * P;
  localparam int SUM_W  = 2 * P + 1;
  localparam int PH_W   = IDX_W + 2;   // quadrant + table index, lower phase bits dropped

  localparam logic [IDX_W:0]              E_X      = (IDX_W + 1)'(E);
  localparam logic signed [SUM_W-1:0]     ROUND_K  = SUM_W'(2 ** (P - 2));
  localparam logic signed [SUM_W-1:0]     SAT_HI   = SUM_W'(2 ** (P - 1) - 1);
  localparam logic signed [SUM_W-1:0]     SAT_LO   = ~SAT_HI;

  // Quarter-wave sine entry, evaluated at elaboration with a Taylor series.
  function automatic logic signed [P-1:0] sin_entry_f(input int k);
    real x;
    real term;
    real acc;
    logic signed [31:0] r;
    x    = 3.14159265358979323846 / 2.0 * real'(k) / real'(E);
    term = x;
    acc  = x;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    r = $rtoi(real'(2 ** (P - 1) - 1) * acc + 0.5);
    return r[P-1:0];
  endfunction

  // Round half up, shift back to sample scale and clamp; MSB flags a clamp.
  function automatic logic [P:0] round_sat_f(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] sh;
    logic [P:0] res;
    sh = (v + ROUND_K) >>> (P - 1);
    if (sh > SAT_HI) begin
      res = {1'b1, SAT_HI[P-1:0]};
    end else if (sh < SAT_LO) begin
      res = {1'b1, SAT_LO[P-1:0]};
    end else begin
      res = {1'b0, sh[P-1:0]};
    end
    return res;
  endfunction

  // Constant quarter-wave table, E+1 entries
  logic signed [P-1:0] tbl_s [0:E];
  for (genvar k = 0; k <= E; k++) begin : g_tbl
    localparam logic signed [P-1:0] ENTRY = sin_entry_f(k);
    assign tbl_s[k] = ENTRY;
  end

  // Phase accumulators and stage registers
  logic [W-1:0]                    acc_r      [N_CARRIERS];
  logic [W-1:0]                    acc_nxt_s  [N_CARRIERS];
  logic [PH_W-1:0]                 ph_use_s   [N_CARRIERS];
  logic                            ev_s;

  logic [N_ANTENNAS-1:0]           valid1_r, valid2_r, valid3_r, valid4_r;
  logic [2*P-1:0]                  data1_r    [N_ANTENNAS];
  logic [2*P-1:0]                  data2_r    [N_ANTENNAS];
  logic [PH_W-1:0]                 phase1_r   [N_CARRIERS];

  logic [IDX_W:0]                  idx_a_s    [N_CARRIERS];
  logic [IDX_W:0]                  idx_b_s    [N_CARRIERS];
  logic signed [P-1:0]             sin_s      [N_CARRIERS];
  logic signed [P-1:0]             cos_s      [N_CARRIERS];
  logic signed [P-1:0]             sin2_r     [N_CARRIERS];
  logic signed [P-1:0]             cos2_r     [N_CARRIERS];

  logic signed [PROD_W-1:0]        i2_x_s     [N_ANTENNAS];
  logic signed [PROD_W-1:0]        q2_x_s     [N_ANTENNAS];
  logic signed [PROD_W-1:0]        sin2_x_s   [N_CARRIERS];
  logic signed [PROD_W-1:0]        cos2_x_s   [N_CARRIERS];
  logic signed [PROD_W-1:0]        ic3_r      [N_CARRIERS][N_ANTENNAS];
  logic signed [PROD_W-1:0]        qs3_r      [N_CARRIERS][N_ANTENNAS];
  logic signed [PROD_W-1:0]        qc3_r      [N_CARRIERS][N_ANTENNAS];
  logic signed [PROD_W-1:0]        is3_r      [N_CARRIERS][N_ANTENNAS];
  logic signed [SUM_W-1:0]         isum4_r    [N_CARRIERS][N_ANTENNAS];
  logic signed [SUM_W-1:0]         qsum4_r    [N_CARRIERS][N_ANTENNAS];

  logic [P:0]                      ri_s       [N_CARRIERS][N_ANTENNAS];
  logic [P:0]                      rq_s       [N_CARRIERS][N_ANTENNAS];
  logic [N_CARRIERS-1:0][N_ANTENNAS-1:0] sat_hit_s;

  // Phase used by this cycle's sample and the accumulator's next value
  always_comb begin
    ev_s = |tvalid_in;
    for (int c = 0; c < N_CARRIERS; c++) begin
      ph_use_s[c]  = '0;
      acc_nxt_s[c] = acc_r[c];
      if (nco_phase_rst) begin
        ph_use_s[c]  = '0;
        acc_nxt_s[c] = ev_s ? nco_coef[c] : '0;
      end else begin
        ph_use_s[c]  = acc_r[c][W-1 -: PH_W];
        acc_nxt_s[c] = ev_s ? (acc_r[c] + nco_coef[c]) : acc_r[c];
      end
    end
  end

  // Stage 1: accumulator update, input and phase capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid1_r <= '0;
      for (int c = 0; c < N_CARRIERS; c++) begin
        acc_r[c]    <= '0;
        phase1_r[c] <= '0;
      end
      for (int a = 0; a < N_ANTENNAS; a++) begin
        data1_r[a] <= '0;
      end
    end else begin
      valid1_r <= tvalid_in;
      for (int c = 0; c < N_CARRIERS; c++) begin
        acc_r[c]    <= acc_nxt_s[c];
        phase1_r[c] <= ph_use_s[c];
      end
      for (int a = 0; a < N_ANTENNAS; a++) begin
        data1_r[a] <= tdata_in[a];
      end
    end
  end

  // Quadrant folding of the quarter-wave table into sin/cos
  always_comb begin
    for (int c = 0; c < N_CARRIERS; c++) begin
      idx_a_s[c] = {1'b0, phase1_r[c][IDX_W-1:0]};
      idx_b_s[c] = E_X - idx_a_s[c];
      sin_s[c]   = '0;
      cos_s[c]   = '0;
      case (phase1_r[c][PH_W-1 -: 2])
        2'd0: begin sin_s[c] =  tbl_s[idx_a_s[c]]; cos_s[c] =  tbl_s[idx_b_s[c]]; end
        2'd1: begin sin_s[c] =  tbl_s[idx_b_s[c]]; cos_s[c] = -tbl_s[idx_a_s[c]]; end
        2'd2: begin sin_s[c] = -tbl_s[idx_a_s[c]]; cos_s[c] = -tbl_s[idx_b_s[c]]; end
        2'd3: begin sin_s[c] = -tbl_s[idx_b_s[c]]; cos_s[c] =  tbl_s[idx_a_s[c]]; end
        default: begin sin_s[c] = '0; cos_s[c] = '0; end
      endcase
    end
  end

  // Stage 2: table read register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid2_r <= '0;
      for (int c = 0; c < N_CARRIERS; c++) begin
        sin2_r[c] <= '0;
        cos2_r[c] <= '0;
      end
      for (int a = 0; a < N_ANTENNAS; a++) begin
        data2_r[a] <= '0;
      end
    end else begin
      valid2_r <= valid1_r;
      for (int c = 0; c < N_CARRIERS; c++) begin
        sin2_r[c] <= sin_s[c];
        cos2_r[c] <= cos_s[c];
      end
      for (int a = 0; a < N_ANTENNAS; a++) begin
        data2_r[a] <= data1_r[a];
      end
    end
  end

  // Sign-extend operands to full product width
  always_comb begin
    for (int a = 0; a < N_ANTENNAS; a++) begin
      i2_x_s[a] = {{P{data2_r[a][P-1]}}, data2_r[a][P-1:0]};
      q2_x_s[a] = {{P{data2_r[a][2*P-1]}}, data2_r[a][2*P-1:P]};
    end
    for (int c = 0; c < N_CARRIERS; c++) begin
      sin2_x_s[c] = {{P{sin2_r[c][P-1]}}, sin2_r[c]};
      cos2_x_s[c] = {{P{cos2_r[c][P-1]}}, cos2_r[c]};
    end
  end

  // Stages 3 and 4: full-precision products, then sums
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid3_r <= '0;
      valid4_r <= '0;
      for (int c = 0; c < N_CARRIERS; c++) begin
        for (int a = 0; a < N_ANTENNAS; a++) begin
          ic3_r[c][a]   <= '0;
          qs3_r[c][a]   <= '0;
          qc3_r[c][a]   <= '0;
          is3_r[c][a]   <= '0;
          isum4_r[c][a] <= '0;
          qsum4_r[c][a] <= '0;
        end
      end
    end else begin
      valid3_r <= valid2_r;
      valid4_r <= valid3_r;
      for (int c = 0; c < N_CARRIERS; c++) begin
        for (int a = 0; a < N_ANTENNAS; a++) begin
          ic3_r[c][a]   <= i2_x_s[a] * cos2_x_s[c];
          qs3_r[c][a]   <= q2_x_s[a] * sin2_x_s[c];
          qc3_r[c][a]   <= q2_x_s[a] * cos2_x_s[c];
          is3_r[c][a]   <= i2_x_s[a] * sin2_x_s[c];
          isum4_r[c][a] <= SUM_W'(ic3_r[c][a]) + SUM_W'(qs3_r[c][a]);
          qsum4_r[c][a] <= SUM_W'(qc3_r[c][a]) - SUM_W'(is3_r[c][a]);
        end
      end
    end
  end

  // Round/saturate each sum and flag clamps on valid outputs
  always_comb begin
    for (int c = 0; c < N_CARRIERS; c++) begin
      for (int a = 0; a < N_ANTENNAS; a++) begin
        ri_s[c][a]      = round_sat_f(isum4_r[c][a]);
        rq_s[c][a]      = round_sat_f(qsum4_r[c][a]);
        sat_hit_s[c][a] = valid4_r[a] & (ri_s[c][a][P] | rq_s[c][a][P]);
      end
    end
  end

  // Stage 5: output register; data holds while valid is low, sat is sticky
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tvalid_out <= '0;
      tdata_out  <= '0;
      sat_flag   <= '0;
    end else begin
      for (int c = 0; c < N_CARRIERS; c++) begin
        for (int a = 0; a < N_ANTENNAS; a++) begin
          tvalid_out[c][a] <= valid4_r[a];
          if (valid4_r[a]) begin
            tdata_out[c][a] <= {rq_s[c][a][P-1:0], ri_s[c][a][P-1:0]};
          end
        end
        sat_flag[c] <= sat_flag[c] | (|sat_hit_s[c]);
      end
    end
  end

endmodule

// File: tb/tb_jb_dfe_demixer.sv
// Self-checking bench for jb_dfe_demixer: a reference model pushes the
// expected output state of every cycle into a queue, which is popped and
// compared five cycles later. A few directed results are also checked
// against hand-computed constants.
module tb_jb_dfe_demixer;

  localparam int NC = 2;
  localparam int NA = 4;
  localparam int W  = 32;
  localparam int E  = 1024;
  localparam int P  = 16;
  localparam real PI_R = 3.14159265358979323846;

  logic                          clk = 1'b0;
  logic                          resetn;
  logic [NC-1:0][W-1:0]          nco_coef;
  logic                          nco_phase_rst;
  logic [NA-1:0]                 tvalid_in;
  logic [NA-1:0][2*P-1:0]        tdata_in;
  logic [NC-1:0][NA-1:0]         tvalid_out;
  logic [NC-1:0][NA-1:0][2*P-1:0] tdata_out;
  logic [NC-1:0]                 sat_flag;

  typedef struct {
    logic [NC-1:0][NA-1:0]          vld;
    logic [NC-1:0][NA-1:0][2*P-1:0] dat;
    logic [NC-1:0]                  sat;
  } exp_t;

  exp_t                           sb_q [$];
  int                             tbl [0:E];
  logic [W-1:0]                   m_acc [NC];
  logic [NC-1:0][NA-1:0][2*P-1:0] m_out;
  logic [NC-1:0]                  m_sat;
  int                             n_cmp;
  int                             n_bad;

  jb_dfe_demixer #(
    .N_CARRIERS(NC), .N_ANTENNAS(NA), .NCO_ACC_WIDTH(W),
    .NCO_QUAD_LKUP_TBL_ENTRIES(E), .PRECISION(P)
  ) dut (
    .clk(clk), .resetn(resetn), .nco_coef(nco_coef), .nco_phase_rst(nco_phase_rst),
    .tvalid_in(tvalid_in), .tdata_in(tdata_in), .tvalid_out(tvalid_out),
    .tdata_out(tdata_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [16:0] m_rnd(input longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 64'sd32767) return {1'b1, 16'h7FFF};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic push_exp(input logic [NA-1:0] v, input logic [NA-1:0][2*P-1:0] d, input logic prst);
    exp_t e;
    logic ev;
    logic [W-1:0] phi;
    int q, idx;
    longint s, cc, iv, qv;
    logic [16:0] ri, rq;
    ev = |v;
    for (int c = 0; c < NC; c++) begin
      phi = prst ? 32'd0 : m_acc[c];
      q   = int'(phi[31:30]);
      idx = int'(phi[29:20]);
      case (q)
        0: begin s =  tbl[idx];     cc =  tbl[E - idx]; end
        1: begin s =  tbl[E - idx]; cc = -tbl[idx];     end
        2: begin s = -tbl[idx];     cc = -tbl[E - idx]; end
        default: begin s = -tbl[E - idx]; cc = tbl[idx]; end
      endcase
      for (int a = 0; a < NA; a++) begin
        if (v[a]) begin
          iv = longint'($signed(d[a][15:0]));
          qv = longint'($signed(d[a][31:16]));
          ri = m_rnd(iv * cc + qv * s);
          rq = m_rnd(qv * cc - iv * s);
          m_out[c][a] = {rq[15:0], ri[15:0]};
          if (ri[16] || rq[16]) m_sat[c] = 1'b1;
        end
      end
      if (prst) m_acc[c] = ev ? nco_coef[c] : 32'd0;
      else if (ev) m_acc[c] = m_acc[c] + nco_coef[c];
    end
    e.vld = {NC{v}};
    e.dat = m_out;
    e.sat = m_sat;
    sb_q.push_back(e);
  endtask

  // Called at a falling edge: check this cycle's outputs, drive one cycle of input.
  task automatic step(input logic [NA-1:0] v, input logic [NA-1:0][2*P-1:0] d, input logic prst);
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("vld", 256'(tvalid_out), 256'(e.vld));
      check_val("dat", 256'(tdata_out), 256'(e.dat));
      check_val("sat", 256'(sat_flag), 256'(e.sat));
    end
    tvalid_in     = v;
    tdata_in      = d;
    nco_phase_rst = prst;
    push_exp(v, d, prst);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  task automatic do_reset();
    exp_t e;
    resetn        = 1'b0;
    tvalid_in     = '0;
    tdata_in      = '0;
    nco_phase_rst = 1'b0;
    #1;
    check_val("rst_vld", 256'(tvalid_out), 256'd0);
    check_val("rst_dat", 256'(tdata_out), 256'd0);
    check_val("rst_sat", 256'(sat_flag), 256'd0);
    sb_q.delete();
    for (int c = 0; c < NC; c++) m_acc[c] = '0;
    m_out = '0;
    m_sat = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    e.vld = '0;
    e.dat = '0;
    e.sat = '0;
    for (int i = 0; i < 5; i++) sb_q.push_back(e);
  endtask

  initial begin
    logic [NA-1:0][2*P-1:0] d;
    logic [NA-1:0]          v;
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k <= E; k++) begin
      tbl[k] = $rtoi(32767.0 * $sin(PI_R / 2.0 * real'(k) / real'(E)) + 0.5);
    end
    nco_coef = '0;
    do_reset();

    // Zero coefficient: output equals input on every carrier
    d = '0; d[0] = 32'h0000_4000;
    step(4'b0001, d, 1'b0);
    idle(4);
    check_val("z_vld",  256'(tvalid_out), 256'({4'b0001, 4'b0001}));
    check_val("z_c0",   256'(tdata_out[0][0]), 256'(32'h0000_4000));
    check_val("z_c1",   256'(tdata_out[1][0]), 256'(32'h0000_4000));
    check_val("z_sat",  256'(sat_flag), 256'd0);
    idle(2);

    // Quarter-turn increment on carrier 0
    nco_coef[0] = 32'h4000_0000;
    nco_coef[1] = 32'h0000_0000;
    step(4'b0001, d, 1'b0);
    step(4'b0001, d, 1'b0);
    idle(5);
    check_val("q90_c0", 256'(tdata_out[0][0]), 256'(32'hC001_0000));
    check_val("q90_c1", 256'(tdata_out[1][0]), 256'(32'h0000_4000));

    // Phase reset coincident with the 4th event, then 90 degrees
    step(4'b0001, d, 1'b0);
    d[0] = 32'hF830_03E8;
    step(4'b0001, d, 1'b1);
    step(4'b0001, d, 1'b0);
    idle(3);
    check_val("prst_0",  256'(tdata_out[0][0]), 256'(32'hF830_03E8));
    idle(1);
    check_val("prst_90", 256'(tdata_out[0][0]), 256'(32'hFC18_F830));

    // 45 degrees with full-scale input saturates I
    nco_coef[0] = 32'h2000_0000;
    nco_coef[1] = 32'h2000_0000;
    step('0, '0, 1'b1);
    d = '0;
    step(4'b0001, d, 1'b0);
    d[0] = 32'h7FFF_7FFF;
    step(4'b0001, d, 1'b0);
    idle(5);
    check_val("s45_c0",  256'(tdata_out[0][0]), 256'(32'h0000_7FFF));
    check_val("s45_c1",  256'(tdata_out[1][0]), 256'(32'h0000_7FFF));
    check_val("s45_sat", 256'(sat_flag), 256'(2'b11));

    // Random traffic with gaps, coefficient changes and phase resets
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 0) begin
        nco_coef[0] = $urandom;
        nco_coef[1] = $urandom;
      end
      v = 4'($urandom_range(0, 15));
      for (int a = 0; a < NA; a++) d[a] = $urandom;
      step(v, d, ($urandom_range(0, 15) == 0));
    end
    idle(5);
    check_val("sat_sticky", 256'(sat_flag), 256'(2'b11));

    // Reset with three samples in flight
    nco_coef[0] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < NA; a++) d[a] = $urandom;
      step(4'b1111, d, 1'b0);
    end
    do_reset();
    idle(6);
    d = '0; d[0] = 32'h0000_4000;
    step(4'b0001, d, 1'b0);
    idle(4);
    check_val("post_rst", 256'(tdata_out[0][0]), 256'(32'h0000_4000));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
